ram_sdp_be: RTL and testbench
=============================

Name: ram_sdp_be

Overview:
Parametrised simple-dual-port synchronous RAM: one write port and one independent read port on a single clock. Successor to the single-port word RAM, adding:
- per-byte write enables
- configurable read latency
- defined read-during-write behaviour
- read-valid and collision flags

Intended as the general storage macro for buffers and register files in the sequential-circuit library.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH words, full decode.
- RD_LATENCY, 1: cycles from sampled rd_en to rd_valid; legal values are 1 and 2.
- WR_FIRST, 1: same-address read/write in one cycle. 1 returns the merged new data; 0 returns the old data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request, sampled at posedge clk.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k].
- rd_en  in  1  read request, sampled at posedge clk.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data, registered.
- rd_valid  out  1  one-cycle pulse: rd_data holds the result of a read.
- collision  out  1  pulses together with rd_valid when that read collided with a write.

Behaviour:
- Reset is asynchronous and active-low on rst_n, with a single clock clk.
- While rst_n=0: rd_data=0, rd_valid=0, collision=0, and all read-pipeline stages are cleared.
- Memory array is not reset. Its contents survive a reset pulse; contents are undefined only at power-up.
- Write: at posedge with wr_en=1, for every k with wr_be[k]=1, mem[wr_addr] byte k <= wr_data byte k. Other bytes are unchanged.
- wr_en=1 with wr_be=0 is a no-op and never counts as a collision.
- Read: rd_en=1 sampled at edge N gives rd_valid=1 during cycle N+RD_LATENCY, for exactly one cycle per request.
- Reads may be issued every cycle, giving full throughput; results return in issue order.
- rd_data updates only on a valid return and holds its last value otherwise.
- With RD_LATENCY=2, the array read is registered into an internal stage, then into rd_data. Both stages carry valid and collision bits.
- Collision is rd_en & wr_en & (rd_addr==wr_addr) & (|wr_be) at the same edge:
  - WR_FIRST=1: returned word takes wr_data bytes where wr_be=1 and the old bytes elsewhere, i.e. the post-write value.
  - WR_FIRST=0: returned word is the pre-write value.
  - The write itself always completes normally.
  - collision=1 in the same cycle as the matching rd_valid; otherwise 0.
- A read of an address written at an earlier edge always sees the new value; there is no stale window.
- Reset mid-operation: in-flight reads are discarded, with no rd_valid after rst_n deasserts. Requests are accepted again from the first edge after release.
- Out-of-range addresses are impossible (full decode). Address wrap from 2**ADDR_WIDTH-1 to 0 is the caller's concern.
- Elaboration error if DATA_WIDTH%8 != 0 or RD_LATENCY is not in {1,2}.

Decomposition:
- Shared package/header ram_pkg holds:
  - BYTE_W function (DATA_WIDTH/8)
  - RD_LATENCY_MIN=1 and RD_LATENCY_MAX=2 constants
  - the byte-merge function: old word, new word, be -> merged word, reused by the model and the scoreboard
- One natural sub-module: ram_rd_pipe, the parametrised valid/data/collision delay stage, instantiated RD_LATENCY-1 times after the array read register.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=5):
1. Reset and idle: rst_n=0 for 3 cycles, then release with no requests -> rd_data=0x00000000, rd_valid=0, collision=0 throughout.
2. Basic latency: write 0xDEADBEEF to addr 3 with be=4'hF, read addr 3 on the next edge.
   - RD_LATENCY=1: rd_valid and rd_data=0xDEADBEEF one cycle later.
   - RD_LATENCY=2: two cycles later.
3. Byte enables: addr 3 holds 0xDEADBEEF; write 0x11223344 with be=4'b0101, then read -> 0xDE22BE44. A write with be=4'b0000 leaves 0xDE22BE44 unchanged.
4. Collision: addr 7 holds 0xAAAAAAAA; at the same edge write 0x55555555 with be=4'b0011 and read addr 7.
   - WR_FIRST=1: rd_data=0xAAAA5555, collision=1.
   - WR_FIRST=0: rd_data=0xAAAAAAAA, collision=1.
   - A following read returns 0xAAAA5555 with collision=0.
5. Streaming: write addr i with data 0x100+i for i=0..31, then rd_en held high while addr sweeps 0..31 and wraps to 0 -> 33 consecutive rd_valid cycles, data 0x100..0x11F then 0x100, in order.
6. Reset mid-read (RD_LATENCY=2): issue a read of addr 5 (holds 0x12345678) and pull rst_n low one cycle later -> no rd_valid for that read. After release, a read of addr 5 returns 0x12345678, confirming memory was preserved.

Source files
------------

// File: rtl/ram_pkg.sv
// ============================================================================
// Module : ram_pkg
// Brief  : Shared constants and byte-merge helper for the SDP byte-enable RAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_MAX_W    = 256;
    localparam int MERGE_MAX_BE_W = MERGE_MAX_W / 8;

    function automatic int BYTE_W(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]    old_word,
        input logic [MERGE_MAX_W-1:0]    new_word,
        input logic [MERGE_MAX_BE_W-1:0] be
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MERGE_MAX_BE_W; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_pipe.sv
// ============================================================================
// Module : ram_rd_pipe
// Brief  : One registered delay stage for read valid, data and collision.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_rd_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  coll_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  coll_o
);

    logic                  valid_q;
    logic                  coll_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Data only moves with a valid beat so the output holds between returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            coll_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            coll_q  <= valid_i & coll_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign coll_o  = coll_q;

endmodule

`default_nettype wire

// File: rtl/ram_sdp_be.sv
// ============================================================================
// Module : ram_sdp_be
// Brief  : Simple-dual-port RAM with byte enables and 1/2-cycle read latency.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LATENCY = 1,
    parameter int WR_FIRST   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    collision
);

    localparam int BW    = BYTE_W(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MERGE_MAX_W) begin : g_bad_width
        $error("ram_sdp_be: DATA_WIDTH must be a multiple of 8 and at most %0d", MERGE_MAX_W);
    end

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("ram_sdp_be: RD_LATENCY must be %0d or %0d", RD_LATENCY_MIN, RD_LATENCY_MAX);
    end

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BW-1:0]         be
    );
        logic [MERGE_MAX_W-1:0] wide;
        wide = byte_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word), MERGE_MAX_BE_W'(be));
        return wide[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_act;
    logic                  rd_coll;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s0_data_d;

    logic                  s0_valid_q;
    logic                  s0_coll_q;
    logic [DATA_WIDTH-1:0] s0_data_q;

    assign wr_act  = wr_en & (|wr_be);
    assign rd_coll = rd_en & wr_act & (rd_addr == wr_addr);
    assign rd_word = mem_q[rd_addr];
    assign wr_word = merge_word(mem_q[wr_addr], wr_data, wr_be);

    // Array is deliberately left out of reset so contents survive rst_n pulses.
    always_ff @(posedge clk) begin
        if (wr_act) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    // On collision rd_word is the pre-write value; write-first forwards the merge.
    always_comb begin
        s0_data_d = rd_word;
        if (rd_coll && (WR_FIRST != 0)) begin
            s0_data_d = merge_word(rd_word, wr_data, wr_be);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_coll_q  <= 1'b0;
            s0_data_q  <= '0;
        end else begin
            s0_valid_q <= rd_en;
            s0_coll_q  <= rd_coll;
            if (rd_en) begin
                s0_data_q <= s0_data_d;
            end
        end
    end

    logic                  st_valid [RD_LATENCY];
    logic                  st_coll  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] st_data  [RD_LATENCY];

    assign st_valid[0] = s0_valid_q;
    assign st_coll[0]  = s0_coll_q;
    assign st_data[0]  = s0_data_q;

    for (genvar i = 1; i < RD_LATENCY; i++) begin : g_pipe
        ram_rd_pipe #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (st_valid[i-1]),
            .data_i  (st_data[i-1]),
            .coll_i  (st_coll[i-1]),
            .valid_o (st_valid[i]),
            .data_o  (st_data[i]),
            .coll_o  (st_coll[i])
        );
    end

    assign rd_valid  = st_valid[RD_LATENCY-1];
    assign collision = st_coll[RD_LATENCY-1];
    assign rd_data   = st_data[RD_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_ram_sdp_be.sv
// ============================================================================
// Module : tb_ram_sdp_be
// Brief  : Directed stimulus with queued expectations checked by a monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_sdp_be;

    parameter int LAT      = 1;
    parameter int WR_FIRST = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        collision;

    ram_sdp_be #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .RD_LATENCY (LAT),
        .WR_FIRST   (WR_FIRST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .collision (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        coll;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
            check("reset collision", {31'd0, collision}, 32'd0);
            check("reset rd_data", rd_data, 32'd0);
            last_data = '0;
        end else if (rd_valid) begin
            if (sb.size() == 0) begin
                check("spurious rd_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", rd_data, e.data);
                check("collision", {31'd0, collision}, {31'd0, e.coll});
                check("latency cycle", 32'(cyc), 32'(e.due));
            end
            last_data = rd_data;
        end else begin
            check("idle collision", {31'd0, collision}, 32'd0);
            check("rd_data hold", rd_data, last_data);
        end
    end

    // One cycle of stimulus; a read pushes its hand-computed expectation.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [4:0] ra,
                         input logic [31:0] ed, input logic ec);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        if (re) sb.push_back('{data: ed, coll: ec, due: cyc + LAT});
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Basic latency: write then read on the following edge
        drive(1, 5'd3, 32'hDEADBEEF, 4'hF, 0, 5'd0, 32'h0, 0);
        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd3, 32'hDEADBEEF, 0);
        idle(3);

        // Byte enables, then a be=0 write that must not alter data or collide
        drive(1, 5'd3, 32'h11223344, 4'b0101, 0, 5'd0, 32'h0, 0);
        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd3, 32'hDE22BE44, 0);
        drive(1, 5'd3, 32'hFFFFFFFF, 4'b0000, 1, 5'd3, 32'hDE22BE44, 0);
        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd3, 32'hDE22BE44, 0);
        idle(3);

        // Same-address collision
        drive(1, 5'd7, 32'hAAAAAAAA, 4'hF, 0, 5'd0, 32'h0, 0);
        drive(1, 5'd7, 32'h55555555, 4'b0011, 1, 5'd7,
              (WR_FIRST != 0) ? 32'hAAAA5555 : 32'hAAAAAAAA, 1);
        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd7, 32'hAAAA5555, 0);
        idle(3);

        // Streaming: fill, then 33 back-to-back reads wrapping to address 0
        for (int i = 0; i < 32; i++) begin
            drive(1, 5'(i), 32'h100 + 32'(i), 4'hF, 0, 5'd0, 32'h0, 0);
        end
        for (int i = 0; i < 33; i++) begin
            drive(0, 5'd0, 32'h0, 4'h0, 1, 5'(i % 32), 32'h100 + 32'(i % 32), 0);
        end
        idle(4);

        // Reset while a read is in flight; memory must survive
        drive(1, 5'd5, 32'h12345678, 4'hF, 0, 5'd0, 32'h0, 0);
        if (LAT >= 2) begin
            drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd5, 32'h0, 0);
            sb.delete();
            rst_n = 1'b0;
        end else begin
            drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd5, 32'h12345678, 0);
            idle(1);
            rst_n = 1'b0;
        end
        idle(2);
        rst_n = 1'b1;
        idle(3);
        drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd5, 32'h12345678, 0);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
        idle(2);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
